// File: rtl/rename_map_cp.sv
// Register rename map with per-branch checkpoints.
// Renames a group of uops per cycle; recovery restores a snapshot.
module rename_map_cp #(
  parameter int RENAME_WIDTH = 2,
  parameter int ARF_SIZE = 32,
  parameter int PRF_SIZE = 64,
  parameter int CP_DEPTH = 4,
  localparam int AW = $clog2(ARF_SIZE),
  localparam int PW = $clog2(PRF_SIZE),
  localparam int CW = $clog2(CP_DEPTH)
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [RENAME_WIDTH-1:0] uop_valid,
  input  logic [RENAME_WIDTH-1:0] is_branch,
  input  logic [RENAME_WIDTH-1:0] rd_valid,
  input  logic [RENAME_WIDTH-1:0][AW-1:0] rs1,
  input  logic [RENAME_WIDTH-1:0][AW-1:0] rs2,
  input  logic [RENAME_WIDTH-1:0][AW-1:0] rd,
  input  logic [RENAME_WIDTH-1:0][PW-1:0] prd_new,
  output logic out_valid,
  output logic [RENAME_WIDTH-1:0] out_uop_valid,
  output logic [RENAME_WIDTH-1:0][PW-1:0] prs1,
  output logic [RENAME_WIDTH-1:0][PW-1:0] prs2,
  output logic [RENAME_WIDTH-1:0][PW-1:0] prev_prd,
  output logic [RENAME_WIDTH-1:0] prev_prd_valid,
  output logic [RENAME_WIDTH-1:0][CW-1:0] cp_index,
  input  logic release_valid,
  input  logic recover_valid,
  input  logic [CW-1:0] recover_idx,
  output logic [CW:0] cp_count
);

  logic [PW-1:0] map_q [ARF_SIZE];
  logic [PW-1:0] cp_map [CP_DEPTH][ARF_SIZE];
  logic [CW-1:0] head_q;
  logic [CW-1:0] tail_q;
  logic [CW-1:0] head_n;
  logic [CW:0] cnt_q;
  logic [CW:0] nbr;
  logic [CW:0] rec_cnt;
  logic [CW-1:0] cp_ptr;
  logic accept;
  logic rel;

  logic [PW-1:0] view [ARF_SIZE];
  logic [PW-1:0] snap [RENAME_WIDTH][ARF_SIZE];
  logic [RENAME_WIDTH-1:0] ren;
  logic [RENAME_WIDTH-1:0] br;
  logic [RENAME_WIDTH-1:0][PW-1:0] s1;
  logic [RENAME_WIDTH-1:0][PW-1:0] s2;
  logic [RENAME_WIDTH-1:0][PW-1:0] pv;
  logic [RENAME_WIDTH-1:0][CW-1:0] ci;

  assign in_ready = ((CW+1)'(CP_DEPTH) - cnt_q
                     >= (CW+1)'(RENAME_WIDTH))
                    && !recover_valid;
  assign accept = in_valid && in_ready;
  assign cp_count = cnt_q;

  assign rel = release_valid && (cnt_q != '0);
  assign head_n = rel ? head_q + CW'(1) : head_q;

  // Releasing the very slot being recovered empties the buffer.
  assign rec_cnt = (rel && recover_idx == head_q)
                   ? '0
                   : {1'b0, recover_idx - head_n}
                     + (CW+1)'(1);

  // Walk the slots in order so later slots see earlier renames.
  always_comb begin
    for (int a = 0; a < ARF_SIZE; a++) begin
      view[a] = map_q[a];
    end
    cp_ptr = tail_q;
    nbr = '0;
    ren = '0;
    br = '0;
    s1 = '0;
    s2 = '0;
    pv = '0;
    ci = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      for (int a = 0; a < ARF_SIZE; a++) begin
        snap[i][a] = '0;
      end
    end
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      s1[i] = view[rs1[i]];
      s2[i] = view[rs2[i]];
      pv[i] = view[rd[i]];
      ren[i] = uop_valid[i] && rd_valid[i]
               && (rd[i] != '0);
      if (ren[i]) begin
        view[rd[i]] = prd_new[i];
      end
      for (int a = 0; a < ARF_SIZE; a++) begin
        snap[i][a] = view[a];
      end
      br[i] = uop_valid[i] && is_branch[i];
      if (br[i]) begin
        ci[i] = cp_ptr;
        cp_ptr = cp_ptr + CW'(1);
        nbr = nbr + (CW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (br[i]) begin
          for (int a = 0; a < ARF_SIZE; a++) begin
            cp_map[ci[i]][a] <= snap[i][a];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < ARF_SIZE; a++) begin
        map_q[a] <= PW'(a);
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      out_valid <= 1'b0;
      out_uop_valid <= '0;
      prs1 <= '0;
      prs2 <= '0;
      prev_prd <= '0;
      prev_prd_valid <= '0;
      cp_index <= '0;
    end else begin
      head_q <= head_n;
      if (recover_valid) begin
        for (int a = 0; a < ARF_SIZE; a++) begin
          map_q[a] <= cp_map[recover_idx][a];
        end
        tail_q <= recover_idx + CW'(1);
        cnt_q <= rec_cnt;
        out_valid <= 1'b0;
      end else begin
        cnt_q <= cnt_q
                 + (accept ? nbr : '0)
                 - (CW+1)'(rel);
        out_valid <= accept;
        if (accept) begin
          for (int a = 0; a < ARF_SIZE; a++) begin
            map_q[a] <= view[a];
          end
          tail_q <= cp_ptr;
          out_uop_valid <= uop_valid;
          prs1 <= s1;
          prs2 <= s2;
          prev_prd <= pv;
          prev_prd_valid <= ren;
          cp_index <= ci;
        end
      end
    end
  end

endmodule
